// File: rtl/rename_pkg.sv
// -----------------------------------------------------------------------------
// rename_pkg
// Shared definitions for the two-wide register rename table: default sizes,
// tag/architectural-register types, the per-slot rename record and a helper
// that counts how many free-list tags a rename group consumes.
// -----------------------------------------------------------------------------
package rename_pkg;

    localparam int NUM_ARCH = 16;              // architectural registers
    localparam int TAG_W    = 8;               // physical tag width
    localparam int FL_DEPTH = 5;               // free-list depth at reset
    localparam int ARCH_W   = $clog2(NUM_ARCH);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [ARCH_W-1:0] arch_t;

    // One renamed slot as presented on the output side.
    typedef struct packed {
        logic valid;
        tag_t pdest;
        tag_t pold;
        tag_t psrc_a;
        tag_t psrc_b;
    } slot_rec_t;

    // Number of slots that both are valid and write a destination.
    function automatic logic [1:0] dest_demand(input logic [1:0] dest_writes);
        return {1'b0, dest_writes[0]} + {1'b0, dest_writes[1]};
    endfunction

endpackage

// File: rtl/rename_table.sv
// -----------------------------------------------------------------------------
// rename_table
// Two-wide register rename stage with a speculative map (spec_map) and a
// committed map (arch_map). New tags come from an external free list; the
// previous mapping of a committed register is returned to it.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_dest_en [2]         per-slot valid / writes-destination (slot 0 older)
//   in_dest/in_src_a/in_src_b [2]   per-slot architectural register numbers
//   in_ready                        group accepted when in_ready & |in_valid
//   fl_tag_0/fl_tag_1, fl_num_items free-list head/next tag, tags available
//   fl_read_1/fl_read_2             pop one / two tags
//   fl_write, fl_write_tag          return one tag to the free list
//   out_valid/out_ready             registered output handshake
//   out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b  per-slot results
//   commit_valid/arch/tag           retire one mapping into arch_map
//   flush                           restore spec_map from arch_map
// -----------------------------------------------------------------------------
module rename_table #(
    parameter  int NUM_ARCH = rename_pkg::NUM_ARCH,
    parameter  int TAG_W    = rename_pkg::TAG_W,
    parameter  int FL_DEPTH = rename_pkg::FL_DEPTH,
    localparam int ARCH_W   = $clog2(NUM_ARCH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             in_valid,
    input  logic [1:0]             in_dest_en,
    input  logic [1:0][ARCH_W-1:0] in_dest,
    input  logic [1:0][ARCH_W-1:0] in_src_a,
    input  logic [1:0][ARCH_W-1:0] in_src_b,
    output logic                   in_ready,
    input  logic [TAG_W-1:0]       fl_tag_0,
    input  logic [TAG_W-1:0]       fl_tag_1,
    input  logic [7:0]             fl_num_items,
    output logic                   fl_read_1,
    output logic                   fl_read_2,
    output logic                   fl_write,
    output logic [TAG_W-1:0]       fl_write_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_slot_valid,
    output logic [1:0][TAG_W-1:0]  out_pdest,
    output logic [1:0][TAG_W-1:0]  out_pold,
    output logic [1:0][TAG_W-1:0]  out_psrc_a,
    output logic [1:0][TAG_W-1:0]  out_psrc_b,
    input  logic                   commit_valid,
    input  logic [ARCH_W-1:0]      commit_arch,
    input  logic [TAG_W-1:0]       commit_tag,
    input  logic                   flush
);
    import rename_pkg::*;

    logic [TAG_W-1:0] r_spec_map [NUM_ARCH];
    logic [TAG_W-1:0] r_arch_map [NUM_ARCH];

    logic                  r_out_valid;
    logic [1:0]            r_slot_valid;
    logic [1:0][TAG_W-1:0] r_pdest;
    logic [1:0][TAG_W-1:0] r_pold;
    logic [1:0][TAG_W-1:0] r_psrc_a;
    logic [1:0][TAG_W-1:0] r_psrc_b;

    logic [1:0]            w_dw;
    logic [1:0]            w_n;
    logic                  w_ready;
    logic                  w_accept;
    logic [1:0][TAG_W-1:0] w_slot_tag;
    logic [1:0][TAG_W-1:0] w_pdest;
    logic [1:0][TAG_W-1:0] w_pold;
    logic [1:0][TAG_W-1:0] w_psrc_a;
    logic [1:0][TAG_W-1:0] w_psrc_b;

    always_comb begin
        w_dw     = in_valid & in_dest_en;
        w_n      = dest_demand(w_dw);
        w_ready  = (!r_out_valid || out_ready) && (fl_num_items >= {6'b0, w_n})
                   && !flush && !reset;
        w_accept = w_ready && (|in_valid);

        // Slot 1 takes the head tag when slot 0 does not consume one.
        w_slot_tag[0] = fl_tag_0;
        w_slot_tag[1] = w_dw[0] ? fl_tag_1 : fl_tag_0;

        w_pdest  = '0;
        w_pold   = '0;
        w_psrc_a = '0;
        w_psrc_b = '0;

        if (in_valid[0]) begin
            w_psrc_a[0] = r_spec_map[in_src_a[0]];
            w_psrc_b[0] = r_spec_map[in_src_b[0]];
            if (w_dw[0]) begin
                w_pdest[0] = w_slot_tag[0];
                w_pold[0]  = r_spec_map[in_dest[0]];
            end
        end

        // Slot 1 sees slot 0's new mapping before it reaches spec_map.
        if (in_valid[1]) begin
            w_psrc_a[1] = (w_dw[0] && in_src_a[1] == in_dest[0]) ? w_slot_tag[0]
                                                                 : r_spec_map[in_src_a[1]];
            w_psrc_b[1] = (w_dw[0] && in_src_b[1] == in_dest[0]) ? w_slot_tag[0]
                                                                 : r_spec_map[in_src_b[1]];
            if (w_dw[1]) begin
                w_pdest[1] = w_slot_tag[1];
                w_pold[1]  = (w_dw[0] && in_dest[1] == in_dest[0]) ? w_slot_tag[0]
                                                                   : r_spec_map[in_dest[1]];
            end
        end
    end

    assign in_ready     = w_ready;
    assign fl_read_1    = w_accept && (w_n == 2'd1);
    assign fl_read_2    = w_accept && (w_n == 2'd2);
    assign fl_write     = commit_valid && !reset;
    assign fl_write_tag = fl_write ? r_arch_map[commit_arch] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ARCH; i++) begin
                r_spec_map[i] <= TAG_W'(FL_DEPTH + i);
                r_arch_map[i] <= TAG_W'(FL_DEPTH + i);
            end
            r_out_valid  <= 1'b0;
            r_slot_valid <= '0;
            r_pdest      <= '0;
            r_pold       <= '0;
            r_psrc_a     <= '0;
            r_psrc_b     <= '0;
        end else begin
            if (commit_valid)
                r_arch_map[commit_arch] <= commit_tag;

            if (flush) begin
                // Restore from arch_map, folding in this cycle's commit.
                for (int unsigned i = 0; i < NUM_ARCH; i++)
                    r_spec_map[i] <= (commit_valid && commit_arch == ARCH_W'(i))
                                     ? commit_tag : r_arch_map[i];
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                // Slot 1 written last so a shared destination ends with its tag.
                if (w_dw[0]) r_spec_map[in_dest[0]] <= w_slot_tag[0];
                if (w_dw[1]) r_spec_map[in_dest[1]] <= w_slot_tag[1];
                r_out_valid  <= 1'b1;
                r_slot_valid <= in_valid;
                r_pdest      <= w_pdest;
                r_pold       <= w_pold;
                r_psrc_a     <= w_psrc_a;
                r_psrc_b     <= w_psrc_b;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_slot_valid = r_slot_valid;
    assign out_pdest      = r_pdest;
    assign out_pold       = r_pold;
    assign out_psrc_a     = r_psrc_a;
    assign out_psrc_b     = r_psrc_b;

endmodule

// File: tb/tb_rename_table.sv
// -----------------------------------------------------------------------------
// tb_rename_table
// Self-checking bench for rename_table. A reference model of both maps feeds a
// scoreboard queue holding the expected content of the output register.
// -----------------------------------------------------------------------------
module tb_rename_table;

    typedef struct packed {
        logic [1:0]      sv;
        logic [1:0][7:0] pdest;
        logic [1:0][7:0] pold;
        logic [1:0][7:0] psa;
        logic [1:0][7:0] psb;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset, flush, out_ready, commit_valid;
    logic [1:0]      in_valid, in_dest_en;
    logic [1:0][3:0] in_dest, in_src_a, in_src_b;
    logic [7:0]      fl_tag_0, fl_tag_1, fl_num_items, commit_tag;
    logic [3:0]      commit_arch;

    logic            in_ready, fl_read_1, fl_read_2, fl_write, out_valid;
    logic [7:0]      fl_write_tag;
    logic [1:0]      out_slot_valid;
    logic [1:0][7:0] out_pdest, out_pold, out_psrc_a, out_psrc_b;

    logic [7:0] m_spec [16];
    logic [7:0] m_arch [16];
    bit         m_ov;
    exp_t       sb [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    rename_table #(.NUM_ARCH(16), .TAG_W(8), .FL_DEPTH(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_dest_en(in_dest_en),
        .in_dest(in_dest), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .in_ready(in_ready),
        .fl_tag_0(fl_tag_0), .fl_tag_1(fl_tag_1), .fl_num_items(fl_num_items),
        .fl_read_1(fl_read_1), .fl_read_2(fl_read_2),
        .fl_write(fl_write), .fl_write_tag(fl_write_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_slot_valid(out_slot_valid), .out_pdest(out_pdest), .out_pold(out_pold),
        .out_psrc_a(out_psrc_a), .out_psrc_b(out_psrc_b),
        .commit_valid(commit_valid), .commit_arch(commit_arch), .commit_tag(commit_tag),
        .flush(flush)
    );

    function automatic int demand();
        return int'(in_valid[0] & in_dest_en[0]) + int'(in_valid[1] & in_dest_en[1]);
    endfunction

    function automatic bit exp_ready();
        return (!m_ov || out_ready) && (int'(fl_num_items) >= demand()) && !flush && !reset;
    endfunction

    function automatic bit exp_accept();
        return exp_ready() && (in_valid != 2'b00);
    endfunction

    // Expected rename result of the currently driven group against the model map.
    function automatic exp_t predict();
        exp_t       e;
        logic       dw0, dw1;
        logic [7:0] t0, t1;
        e   = '0;
        dw0 = in_valid[0] & in_dest_en[0];
        dw1 = in_valid[1] & in_dest_en[1];
        t0  = fl_tag_0;
        t1  = dw0 ? fl_tag_1 : fl_tag_0;
        e.sv = in_valid;
        if (in_valid[0]) begin
            e.psa[0] = m_spec[in_src_a[0]];
            e.psb[0] = m_spec[in_src_b[0]];
            if (dw0) begin e.pdest[0] = t0; e.pold[0] = m_spec[in_dest[0]]; end
        end
        if (in_valid[1]) begin
            e.psa[1] = (dw0 && in_src_a[1] == in_dest[0]) ? t0 : m_spec[in_src_a[1]];
            e.psb[1] = (dw0 && in_src_b[1] == in_dest[0]) ? t0 : m_spec[in_src_b[1]];
            if (dw1) begin
                e.pdest[1] = t1;
                e.pold[1]  = (dw0 && in_dest[1] == in_dest[0]) ? t0 : m_spec[in_dest[1]];
            end
        end
        return e;
    endfunction

    // Advance the model for the driven inputs, then cross the clock edge.
    task automatic tick();
        bit   acc;
        exp_t e;
        acc = exp_accept();
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_spec[i] = 8'(5 + i);
                m_arch[i] = 8'(5 + i);
            end
            m_ov = 1'b0;
            sb.delete();
        end else begin
            if (m_ov && (out_ready || flush) && sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
                e = predict();
                sb.push_back(e);
                if (in_valid[0] && in_dest_en[0]) m_spec[in_dest[0]] = e.pdest[0];
                if (in_valid[1] && in_dest_en[1]) m_spec[in_dest[1]] = e.pdest[1];
            end
            if (commit_valid) m_arch[commit_arch] = commit_tag;
            if (flush) for (int i = 0; i < 16; i++) m_spec[i] = m_arch[i];
            m_ov = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_ov;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 2'b00; in_dest_en = 2'b00; flush = 1'b0; commit_valid = 1'b0;
        out_ready = 1'b1; fl_num_items = 8'd5;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b1; commit_valid = 1'b1; commit_arch = 4'd2; commit_tag = 8'h44;
        in_valid = 2'b11; in_dest_en = 2'b11;
        #4;
        n_checks++;
        if ({in_ready, fl_read_1, fl_read_2, fl_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_comb: got rdy/r1/r2/wr=%b required 0000",
                     {in_ready, fl_read_1, fl_read_2, fl_write});
        end
        tick();
        tick();
        reset = 1'b0;
        idle();
        #4;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        n_checks++;
        if ({out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b});
        end
        tick();
    endtask

    task automatic test_single();
        exp_t e;
        idle();
        in_valid = 2'b01; in_dest_en = 2'b01;
        in_dest[0] = 4'd3; in_src_a[0] = 4'd1; in_src_b[0] = 4'd2;
        fl_tag_0 = 8'h00; fl_tag_1 = 8'h01;
        #4;
        n_checks++;
        if ({in_ready, fl_read_1, fl_read_2} !== 3'b110) begin
            n_fail++;
            $display("FAIL single_pop: got rdy/r1/r2=%b required 110", {in_ready, fl_read_1, fl_read_2});
        end
        tick();
        idle();
        e = (sb.size() > 0) ? sb[0] : '0;
        n_checks++;
        if (out_valid !== 1'b1 || {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b}
                !== {2'b01, 16'h0000, 16'h0008, 16'h0006, 16'h0007} || sb.size() != 1
                || {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b} !== e) begin
            n_fail++;
            $display("FAIL single_out: got v=%b %h required v=1 %h", out_valid,
                     {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b},
                     {2'b01, 16'h0000, 16'h0008, 16'h0006, 16'h0007});
        end
        #4;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_dual_bypass();
        idle();
        in_valid = 2'b11; in_dest_en = 2'b11;
        in_dest[0] = 4'd1; in_src_a[0] = 4'd2; in_src_b[0] = 4'd2;
        in_dest[1] = 4'd1; in_src_a[1] = 4'd1; in_src_b[1] = 4'd1;
        fl_tag_0 = 8'h00; fl_tag_1 = 8'h01;
        #4;
        n_checks++;
        if ({in_ready, fl_read_1, fl_read_2} !== 3'b101) begin
            n_fail++;
            $display("FAIL dual_pop: got rdy/r1/r2=%b required 101", {in_ready, fl_read_1, fl_read_2});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b}
                !== {2'b11, 16'h0100, 16'h0006, 16'h0007, 16'h0007}) begin
            n_fail++;
            $display("FAIL dual_bypass: got v=%b %h required v=1 %h", out_valid,
                     {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b},
                     {2'b11, 16'h0100, 16'h0006, 16'h0007, 16'h0007});
        end
        // Follow-up reads r1 (now tag 1) and r0; no destination so pdest/pold read 0.
        in_valid = 2'b01; in_dest_en = 2'b00; in_src_a[0] = 4'd1; in_src_b[0] = 4'd0;
        #4;
        tick();
        idle();
        n_checks++;
        if ({out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b}
                !== {2'b01, 16'h0000, 16'h0000, 16'h0001, 16'h0005}) begin
            n_fail++;
            $display("FAIL dual_spec_r1: got %h required %h",
                     {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b},
                     {2'b01, 16'h0000, 16'h0000, 16'h0001, 16'h0005});
        end
        #4;
        tick();
    endtask

    task automatic test_no_tags();
        idle();
        fl_num_items = 8'd1;
        in_valid = 2'b11; in_dest_en = 2'b11;
        in_dest[0] = 4'd8; in_dest[1] = 4'd9;
        #4;
        n_checks++;
        if ({in_ready, fl_read_1, fl_read_2} !== 3'b000) begin
            n_fail++;
            $display("FAIL no_tags_comb: got rdy/r1/r2=%b required 000", {in_ready, fl_read_1, fl_read_2});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL no_tags_out_valid: got %b required 0", out_valid);
        end
        idle();
        #4;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        idle();
        in_valid = 2'b01; in_dest_en = 2'b01;
        in_dest[0] = 4'd7; in_src_a[0] = 4'd2; in_src_b[0] = 4'd4;
        fl_tag_0 = 8'h30; fl_tag_1 = 8'h31;
        #4;
        tick();
        out_ready = 1'b0;
        in_dest[0] = 4'd9; fl_tag_0 = 8'h40;
        for (int c = 0; c < 3; c++) begin
            #4;
            n_checks++;
            if ({in_ready, fl_read_1, fl_read_2} !== 3'b000) begin
                n_fail++;
                $display("FAIL stall_comb[%0d]: got rdy/r1/r2=%b required 000", c,
                         {in_ready, fl_read_1, fl_read_2});
            end
            tick();
            e = (sb.size() > 0) ? sb[0] : '0;
            n_checks++;
            if (out_valid !== 1'b1 || sb.size() != 1
                    || {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b} !== e) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b %h required v=1 %h", c, out_valid,
                         {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b}, e);
            end
        end
        idle();
        #4;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_commit_flush();
        idle();
        commit_valid = 1'b1; commit_arch = 4'd3; commit_tag = 8'h00;
        #4;
        n_checks++;
        if ({fl_write, fl_write_tag} !== {1'b1, 8'h08}) begin
            n_fail++;
            $display("FAIL commit_ret: got wr=%b tag=%h required wr=1 tag=08", fl_write, fl_write_tag);
        end
        tick();
        // Flush together with a commit of r5; the restored map must include it.
        commit_arch = 4'd5; commit_tag = 8'h20; flush = 1'b1;
        #4;
        n_checks++;
        if ({fl_write, fl_write_tag} !== {1'b1, 8'h0A}) begin
            n_fail++;
            $display("FAIL flush_commit_ret: got wr=%b tag=%h required wr=1 tag=0a", fl_write, fl_write_tag);
        end
        tick();
        idle();
        in_valid = 2'b11; in_dest_en = 2'b00;
        in_src_a[0] = 4'd3; in_src_b[0] = 4'd1; in_src_a[1] = 4'd5; in_src_b[1] = 4'd3;
        #4;
        tick();
        idle();
        n_checks++;
        if (out_valid !== 1'b1 || {out_psrc_a, out_psrc_b} !== {8'h20, 8'h00, 8'h00, 8'h06}) begin
            n_fail++;
            $display("FAIL flush_restore: got v=%b psrc_a=%h psrc_b=%h required v=1 psrc_a=2000 psrc_b=0006",
                     out_valid, out_psrc_a, out_psrc_b);
        end
        #4;
        tick();
    endtask

    task automatic test_flush_accept();
        idle();
        flush = 1'b1; in_valid = 2'b11; in_dest_en = 2'b11;
        in_dest[0] = 4'd10; in_dest[1] = 4'd11; fl_tag_0 = 8'h50; fl_tag_1 = 8'h51;
        #4;
        n_checks++;
        if ({in_ready, fl_read_1, fl_read_2} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_block: got rdy/r1/r2=%b required 000", {in_ready, fl_read_1, fl_read_2});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_out: got out_valid=%b required 0", out_valid);
        end
        // A flush also discards a result held under back-pressure.
        flush = 1'b0;
        #4;
        tick();
        flush = 1'b1; out_ready = 1'b0; in_valid = 2'b00;
        #4;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: got out_valid=%b required 0", out_valid);
        end
        idle();
        #4;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   er;
        int   d;
        for (int c = 0; c < 40; c++) begin
            in_valid     = 2'($urandom_range(3));
            in_dest_en   = 2'($urandom_range(3));
            for (int s = 0; s < 2; s++) begin
                in_dest[s]  = 4'($urandom_range(15));
                in_src_a[s] = 4'($urandom_range(15));
                in_src_b[s] = 4'($urandom_range(15));
            end
            fl_tag_0     = 8'($urandom_range(255));
            fl_tag_1     = 8'($urandom_range(255));
            fl_num_items = 8'($urandom_range(5));
            out_ready    = ($urandom_range(3) != 0);
            flush        = ($urandom_range(7) == 0);
            commit_valid = ($urandom_range(2) == 0);
            commit_arch  = 4'($urandom_range(15));
            commit_tag   = 8'($urandom_range(255));
            #4;
            er = exp_ready();
            d  = demand();
            n_checks++;
            if ({in_ready, fl_read_1, fl_read_2} !== {er, er && in_valid != 0 && d == 1,
                                                      er && in_valid != 0 && d == 2}) begin
                n_fail++;
                $display("FAIL b2b_comb[%0d]: got rdy/r1/r2=%b required %b", c,
                         {in_ready, fl_read_1, fl_read_2},
                         {er, er && in_valid != 0 && d == 1, er && in_valid != 0 && d == 2});
            end
            if (commit_valid) begin
                n_checks++;
                if ({fl_write, fl_write_tag} !== {1'b1, m_arch[commit_arch]}) begin
                    n_fail++;
                    $display("FAIL b2b_commit[%0d]: got wr=%b tag=%h required wr=1 tag=%h", c,
                             fl_write, fl_write_tag, m_arch[commit_arch]);
                end
            end
            tick();
            e = (sb.size() > 0) ? sb[0] : '0;
            n_checks++;
            if (out_valid !== m_ov || (m_ov && {out_slot_valid, out_pdest, out_pold,
                                                out_psrc_a, out_psrc_b} !== e)) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got v=%b %h required v=%b %h", c, out_valid,
                         {out_slot_valid, out_pdest, out_pold, out_psrc_a, out_psrc_b}, m_ov, e);
            end
        end
        idle();
        #4;
        tick();
    endtask

    initial begin
        reset = 1'b1; m_ov = 1'b0;
        idle();
        in_dest = '0; in_src_a = '0; in_src_b = '0;
        fl_tag_0 = 8'h00; fl_tag_1 = 8'h01;
        commit_arch = '0; commit_tag = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_dual_bypass();
        test_no_tags();
        test_backpressure();
        test_commit_flush();
        test_flush_accept();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_table.md
RENAME_TABLE -- requirements
Module: rename_table

Interface
REQ-001 Parameters SHALL be: NUM_ARCH (default 16, architectural registers); TAG_W (default 8, physical tag width); FL_DEPTH (default 5, free-list depth).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 in_valid  in  2  per-slot instruction valid; slot 0 is older.
REQ-005 in_dest_en  in  2  per-slot "writes a destination".
REQ-006 in_dest, in_src_a, in_src_b  in  2x4 each  per-slot architectural register numbers.
REQ-007 in_ready  out  1  group accepted this cycle when in_ready and any in_valid are high.
REQ-008 fl_tag_0, fl_tag_1  in  8 each  free-list head tag and next tag.
REQ-009 fl_num_items  in  8  free tags available.
REQ-010 fl_read_1, fl_read_2  out  1 each  pop one or two tags; mutually exclusive.
REQ-011 fl_write, fl_write_tag  out  1/8  return one tag to the free list.
REQ-012 out_valid, out_ready  out/in  1/1  registered output handshake.
REQ-013 out_slot_valid  out  2  per-slot valid.
REQ-014 out_pdest, out_pold, out_psrc_a, out_psrc_b  out  2x8 each  per-slot new tag, previous mapping, source tags.
REQ-015 commit_valid, commit_arch, commit_tag  in  1/4/8  retire one mapping.
REQ-016 flush  in  1  discard speculative state.

Function
REQ-017 Two maps SHALL be kept: speculative (spec_map) and committed (arch_map), each NUM_ARCH x TAG_W.
REQ-018 n = popcount(in_valid & in_dest_en) SHALL be the group's tag demand.
REQ-019 in_ready SHALL be (!out_valid | out_ready) & (fl_num_items >= n) & !flush & !reset; combinational.
REQ-020 On accept: n=1 SHALL assert fl_read_1, n=2 fl_read_2, n=0 neither; never asserted without accept.
REQ-021 Tag assignment: first dest-writing slot SHALL take fl_tag_0, the second fl_tag_1.
REQ-022 Slot 0 sources/old SHALL read spec_map; slot 1 SHALL bypass: src equal to slot 0 dest (slot 0 dest_en) uses slot 0 new tag; same for out_pold.
REQ-023 Same dest in both slots: spec_map SHALL end with slot 1 tag; slot 1 out_pold = slot 0 new tag.
REQ-024 Latency SHALL be 1 cycle: accepted group appears on outputs next edge with out_valid=1.
REQ-025 out_valid & !out_ready SHALL hold all outputs stable.
REQ-026 out_valid SHALL clear on the edge where out_ready=1 and no new accept.
REQ-027 Slots with dest_en=0 SHALL drive out_pdest=out_pold=0.
REQ-028 commit_valid SHALL drive fl_write=1, fl_write_tag=arch_map[commit_arch] (pre-update), combinational; arch_map[commit_arch] <= commit_tag.
REQ-029 flush SHALL, next edge: spec_map <= arch_map including same-cycle commit; out_valid <= 0; no tags popped. Speculative tags are reclaimed outside this block.
REQ-030 flush dominates accept; commit proceeds during flush.

Reset
REQ-031 On reset: spec_map[i] = arch_map[i] = FL_DEPTH + i (free list holds 0..FL_DEPTH-1).
REQ-032 On reset: out_valid=0, all out_* =0, fl_read_1=fl_read_2=fl_write=0.
REQ-033 reset SHALL override flush, commit and accept in the same cycle.

Structure
REQ-034 Shared package rename_pkg SHALL hold NUM_ARCH, TAG_W, FL_DEPTH, tag_t, arch_t and the slot-record struct.
REQ-035 No sub-module is natural; bypass and maps stay in rename_table.

Verification
REQ-036 Reset; slot0 r3<-r1,r2, fl_tag_0=0x00, items=5 -> fl_read_1; next cycle pdest=0x00, pold=0x08, psrc=0x06,0x07.
REQ-037 Slot0 r1<-r2, slot1 r1<-r1,r1, tags 0x00/0x01 -> fl_read_2; slot1 psrc=0x00,0x00, pold=0x00, pdest=0x01; spec r1=0x01.
REQ-038 items=1, two dest slots -> in_ready=0, no pop, out_valid stays 0.
REQ-039 out_valid=1, out_ready=0 three cycles -> outputs frozen, in_ready=0, no pops.
REQ-040 commit r3 tag 0x00 -> fl_write=1, tag 0x08; then flush -> next group reading r3 gets psrc 0x00.
REQ-041 flush with accepted-looking input -> in_ready=0, no pop, out_valid=0 next cycle.
